// File: rtl/vsw_sequencer.sv
// vsw_sequencer: streams up to MAXVL vector-register elements from the regfile into data memory.
module vsw_sequencer #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int MAXVL = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] vreg_base,
  input  logic [DW-1:0] mem_base,
  input  logic [DW-1:0] vlen,
  input  logic [DW-1:0] rd_data,
  output logic [AW-1:0] rd_addr,
  output logic [4:0]    cnt,
  output logic          mem_we,
  output logic [DW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          busy,
  output logic          done
);
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2, FIN = 2'd3;
  logic [1:0] state;
  logic [4:0] n, n_new;
  logic [DW-1:0] base;
  assign n_new = vlen > DW'(MAXVL) ? 5'(MAXVL) : vlen[4:0];
  assign mem_wdata = rd_data;
  assign busy = state != IDLE;
  assign done = state == FIN;
  // each write lands one cycle after its element index goes out, matching regfile read latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      rd_addr <= '0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      n <= '0;
      base <= '0;
    end else begin
      mem_we <= state == ISSUE;
      if (state == ISSUE) mem_addr <= base + (DW'(cnt - 5'd1) << 2);
      case (state)
        IDLE: if (start) begin
          rd_addr <= vreg_base;
          base <= mem_base;
          n <= n_new;
          state <= n_new == 5'd0 ? FIN : ISSUE;
          cnt <= n_new == 5'd0 ? 5'd0 : 5'd1;
        end
        ISSUE: begin
          state <= cnt == n ? DRAIN : ISSUE;
          cnt <= cnt == n ? 5'd0 : cnt + 5'd1;
        end
        DRAIN: state <= FIN;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vsw_sequencer.sv
// tb_vsw_sequencer: randomized checks of vsw_sequencer against an element-list reference model.
module tb_vsw_sequencer;
  localparam int MAXVL = 8;
  logic clk = 0, rst_n = 0, start = 0;
  logic [4:0] vreg_base = 0, rd_addr, cnt, rf_ix;
  logic [31:0] mem_base = 0, vlen = 0, rd_data = 0, mem_addr, mem_wdata;
  logic mem_we, busy, done;
  logic [31:0] gpr [32];
  logic [31:0] last_addr = 0;
  int passed = 0, total = 0;

  vsw_sequencer #(.DW(32), .AW(5), .MAXVL(MAXVL)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .vreg_base(vreg_base), .mem_base(mem_base),
    .vlen(vlen), .rd_data(rd_data), .rd_addr(rd_addr), .cnt(cnt), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // regfile: cnt==k reads element k-1 of the vector at rd_addr, one cycle later
  assign rf_ix = cnt == 5'd0 ? rd_addr : 5'(rd_addr + cnt - 5'd1);
  always @(posedge clk) rd_data <= gpr[rf_ix];

  task automatic fill_gpr();
    for (int i = 0; i < 32; i++) gpr[i] = $urandom;
  endtask

  // issues one store at the current negedge and checks every cycle through the IDLE after done
  task automatic run_seq(input logic [4:0] vb, input logic [31:0] mb, input logic [31:0] vl, input int glitch);
    int n, dn;
    logic exp_we;
    logic [4:0] exp_cnt, ix;
    logic [31:0] ea;
    n = (vl > 32'(MAXVL)) ? MAXVL : int'(vl);
    dn = n == 0 ? 1 : n + 2;
    vreg_base = vb; mem_base = mb; vlen = vl; start = 1;
    for (int c = 1; c <= dn + 1; c++) begin
      @(negedge clk);
      exp_we = n > 0 && c >= 2 && c <= n + 1;
      exp_cnt = (n > 0 && c <= n) ? 5'(c) : 5'd0;
      total++;
      if (mem_we !== exp_we) $display("FAIL mem_we cyc=%0d got=%b exp=%b", c, mem_we, exp_we); else passed++;
      total++;
      if (cnt !== exp_cnt) $display("FAIL cnt cyc=%0d got=%0d exp=%0d", c, cnt, exp_cnt); else passed++;
      total++;
      if (busy !== (c <= dn)) $display("FAIL busy cyc=%0d got=%b exp=%b", c, busy, c <= dn); else passed++;
      total++;
      if (done !== (c == dn)) $display("FAIL done cyc=%0d got=%b exp=%b", c, done, c == dn); else passed++;
      if (exp_we) begin
        ea = mb + 32'(4 * (c - 2));
        last_addr = ea;
        ix = vb + 5'(c - 2);
        total++;
        if (mem_wdata !== gpr[ix]) $display("FAIL wdata cyc=%0d got=%h exp=%h", c, mem_wdata, gpr[ix]); else passed++;
      end
      total++;
      if (mem_addr !== last_addr) $display("FAIL mem_addr cyc=%0d got=%h exp=%h", c, mem_addr, last_addr); else passed++;
      if (c == 1) begin
        total++;
        if (rd_addr !== vb) $display("FAIL rd_addr got=%0d exp=%0d", rd_addr, vb); else passed++;
      end
      start = (c == glitch);
      if (c == glitch) begin
        mem_base = ~mb; vlen = vl + 1; vreg_base = vb + 5'd1;
      end
    end
    start = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(negedge clk);
    total++;
    if ({busy, done, mem_we, cnt, rd_addr, mem_addr} !== 43'd0)
      $display("FAIL reset got busy=%b done=%b we=%b cnt=%0d rd_addr=%0d addr=%h exp=all zero", busy, done, mem_we, cnt, rd_addr, mem_addr);
    else passed++;
    rst_n = 1;
    last_addr = 0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    run_seq(5'd16, 32'h100, 32'd3, 0);
  endtask

  task automatic test_zero_len();
    run_seq(5'd8, 32'h200, 32'd0, 0);
  endtask

  task automatic test_clamp();
    run_seq(5'd8, 32'h1000, 32'd20, 0);
    run_seq(5'd24, 32'h40, 32'h8000_0001, 0);
    run_seq(5'd16, 32'h80, 32'd8, 0);
  endtask

  task automatic test_wrap();
    run_seq(5'd16, 32'hFFFF_FFFC, 32'd2, 0);
  endtask

  task automatic test_start_ignored();
    run_seq(5'd8, 32'h300, 32'd5, 2);
    run_seq(5'd16, 32'h400, 32'd3, 5);
    run_seq(5'd24, 32'h500, 32'd0, 1);
  endtask

  task automatic test_reset_mid();
    int k;
    vreg_base = 5'd8; mem_base = 32'h600; vlen = 32'd5; start = 1;
    @(negedge clk);
    start = 0;
    k = 0;
    while (cnt !== 5'd2 && k < 10) begin @(negedge clk); k++; end
    total++;
    if (cnt !== 5'd2) $display("FAIL reset_mid_wait got cnt=%0d exp=2", cnt); else passed++;
    rst_n = 0;
    #1;
    total++;
    if ({busy, done, mem_we, cnt, rd_addr, mem_addr} !== 43'd0)
      $display("FAIL reset_mid got busy=%b done=%b we=%b cnt=%0d addr=%h exp=all zero", busy, done, mem_we, cnt, mem_addr);
    else passed++;
    repeat (3) begin
      @(negedge clk);
      total++;
      if (mem_we !== 1'b0) $display("FAIL reset_hold_we got=%b exp=0", mem_we); else passed++;
    end
    rst_n = 1;
    last_addr = 0;
    @(negedge clk);
    run_seq(5'd8, 32'h700, 32'd4, 0);
  endtask

  task automatic test_back_to_back_random();
    for (int i = 0; i < 25; i++) begin
      if (i % 5 == 0) fill_gpr();
      run_seq(5'($urandom), $urandom,
              ($urandom_range(0, 4) == 0) ? 32'($urandom) : 32'($urandom_range(0, 10)),
              int'($urandom_range(0, 12)));
    end
  endtask

  initial begin
    fill_gpr();
    test_reset();
    test_basic();
    test_zero_len();
    test_clamp();
    test_wrap();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
